dpll_phase_detect_filter: RTL and testbench



---
 rtl/dpll_pkg.sv | 33 +++
 rtl/dpll_twophase_gen.sv | 38 +++
 rtl/dpll_phase_detect_filter.sv | 96 +++++++++
 tb/tb_dpll_phase_detect_filter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dpll_pkg.sv
//------------------------------------------------------------------------------
// Module   : dpll_pkg
// Brief    : Shared constants and vote encoding for the DQPSK bit-timing DPLL.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dpll_pkg;

  localparam int         N_WALK_DEF = 4;
  localparam int         WW_DEF     = 4;
  localparam logic [1:0] PH_D1      = 2'd0;
  localparam logic [1:0] PH_D2      = 2'd2;

  // Two's-complement encoding so a vote sign-extends directly into the walk sum
  typedef enum logic [1:0] {
    VOTE_NONE  = 2'b00,
    VOTE_EARLY = 2'b01,
    VOTE_LATE  = 2'b11
  } vote_e;

  function automatic vote_e classify_vote(input logic ci, input logic cq);
    if (ci && !cq)
      return VOTE_EARLY;
    else if (cq && !ci)
      return VOTE_LATE;
    else
      return VOTE_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dpll_twophase_gen.sv
//------------------------------------------------------------------------------
// Module   : dpll_twophase_gen
// Brief    : Non-overlapping clk_d1/clk_d2 pulse trains, period 4 clk32 cycles.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dpll_twophase_gen
  import dpll_pkg::*;
(
  input  logic clk32,
  input  logic rst,
  output logic clk_d1,
  output logic clk_d2
);

  logic [1:0] r_ph;
  logic       r_clk_d1;
  logic       r_clk_d2;

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      r_ph     <= 2'd0;
      r_clk_d1 <= 1'b0;
      r_clk_d2 <= 1'b0;
    end else begin
      r_ph     <= r_ph + 2'd1;
      r_clk_d1 <= (r_ph == PH_D1);
      r_clk_d2 <= (r_ph == PH_D2);
    end
  end

  assign clk_d1 = r_clk_d1;
  assign clk_d2 = r_clk_d2;

endmodule

`default_nettype wire

// File: rtl/dpll_phase_detect_filter.sv
//------------------------------------------------------------------------------
// Module   : dpll_phase_detect_filter
// Brief    : DPLL front end: data edge detect, early/late random-walk filter,
//            held divider correction requests and two-phase pulse generation.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dpll_phase_detect_filter
  import dpll_pkg::*;
#(
  parameter int N_WALK = N_WALK_DEF,
  parameter int WW     = WW_DEF
)(
  input  logic                 rst,
  input  logic                 clk32,
  input  logic                 din,
  input  logic                 clk_i,
  input  logic                 clk_q,
  output logic                 clk_d1,
  output logic                 clk_d2,
  output logic                 pd_before,
  output logic                 pd_after,
  output logic signed [WW-1:0] walk
);

  localparam logic signed [WW-1:0] c_walk_pos = WW'(N_WALK);
  localparam logic signed [WW-1:0] c_walk_neg = WW'(-N_WALK);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_sync3;
  logic                 r_pend_b;
  logic                 r_pend_a;
  logic signed [WW-1:0] r_walk;

  logic                 w_edge;
  vote_e                w_vote;
  logic [1:0]           w_vote_bits;
  logic                 w_vote_en;
  logic signed [WW-1:0] w_walk_sum;

  dpll_twophase_gen u_twophase (
    .clk32  (clk32),
    .rst    (rst),
    .clk_d1 (clk_d1),
    .clk_d2 (clk_d2)
  );

  assign w_edge      = r_sync2 ^ r_sync3;
  assign w_vote      = classify_vote(clk_i, clk_q);
  assign w_vote_bits = w_vote;
  // Votes are ignored while any correction is still being handed to the divider
  assign w_vote_en   = w_edge && !r_pend_b && !r_pend_a && (w_vote != VOTE_NONE);
  assign w_walk_sum  = r_walk + {{(WW-2){w_vote_bits[1]}}, w_vote_bits};

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync3  <= 1'b0;
      r_pend_b <= 1'b0;
      r_pend_a <= 1'b0;
      r_walk   <= '0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;

      // Release only after the divider has seen the request during its gate pulse
      if (r_pend_b && clk_d1)
        r_pend_b <= 1'b0;
      if (r_pend_a && clk_d2)
        r_pend_a <= 1'b0;

      if (w_vote_en) begin
        if (w_walk_sum == c_walk_pos) begin
          r_walk   <= '0;
          r_pend_b <= 1'b1;
        end else if (w_walk_sum == c_walk_neg) begin
          r_walk   <= '0;
          r_pend_a <= 1'b1;
        end else begin
          r_walk <= w_walk_sum;
        end
      end
    end
  end

  assign pd_before = r_pend_b;
  assign pd_after  = r_pend_a;
  assign walk      = r_walk;

endmodule

`default_nettype wire

// File: tb/tb_dpll_phase_detect_filter.sv
//------------------------------------------------------------------------------
// Module   : tb_dpll_phase_detect_filter
// Brief    : Directed scoreboard bench for dpll_phase_detect_filter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dpll_phase_detect_filter;

  logic              clk32 = 1'b0;
  logic              rst;
  logic              din;
  logic              clk_i;
  logic              clk_q;
  logic              clk_d1;
  logic              clk_d2;
  logic              pd_before;
  logic              pd_after;
  logic signed [3:0] walk;

  always #5 clk32 = ~clk32;

  dpll_phase_detect_filter #(.N_WALK(4), .WW(4)) dut (
    .rst       (rst),
    .clk32     (clk32),
    .din       (din),
    .clk_i     (clk_i),
    .clk_q     (clk_q),
    .clk_d1    (clk_d1),
    .clk_d2    (clk_d2),
    .pd_before (pd_before),
    .pd_after  (pd_after),
    .walk      (walk)
  );

  // Cycle k is the interval after the k-th clk32 edge following reset release
  int cyc;
  always @(posedge clk32 or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int   cyc;
    int   walk;
    logic pdb;
    logic pda;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation each time walk/pd_before/pd_after change
  initial begin
    int   pw;
    logic pb, pa, pd1, pd2;
    int   hb, ha;
    exp_t e;
    pw = 0; pb = 0; pa = 0; pd1 = 0; pd2 = 0; hb = 0; ha = 0;
    forever begin
      @(negedge clk32);
      if (rst) begin
        check("reset_outputs", int'({clk_d1, clk_d2, pd_before, pd_after, walk}), 0);
        pw = 0; pb = 0; pa = 0; pd1 = 0; pd2 = 0; hb = 0; ha = 0;
      end else begin
        check("clk_d1", int'(clk_d1), int'(cyc % 4 == 1));
        check("clk_d2", int'(clk_d2), int'(cyc % 4 == 3));
        if (pd_before && pd_after) check("pd_exclusive", 1, 0);
        if (pd_before) hb++;
        else begin
          if (hb > 0) begin
            check("pdb_hold_le5", int'(hb <= 5), 1);
            check("pdb_cleared_after_d1", int'(pd1), 1);
          end
          hb = 0;
        end
        if (pd_after) ha++;
        else begin
          if (ha > 0) begin
            check("pda_hold_le5", int'(ha <= 5), 1);
            check("pda_cleared_after_d2", int'(pd2), 1);
          end
          ha = 0;
        end
        if (int'(walk) != pw || pd_before != pb || pd_after != pa) begin
          if (q.size() == 0) begin
            check("unexpected_change_walk", int'(walk), pw);
            check("unexpected_change_pd", int'({pd_before, pd_after}), int'({pb, pa}));
          end else begin
            e = q.pop_front();
            check("walk", int'(walk), e.walk);
            check("pd_before", int'(pd_before), int'(e.pdb));
            check("pd_after", int'(pd_after), int'(e.pda));
            if (e.cyc >= 0) check("event_cycle", cyc, e.cyc);
          end
        end
        pw = int'(walk); pb = pd_before; pa = pd_after; pd1 = clk_d1; pd2 = clk_d2;
      end
    end
  end

  task automatic align(input int ph);
    do @(negedge clk32); while (cyc % 4 != ph);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk32);
  endtask

  // Toggle din in a cycle of phase ph; the walk update lands 3 edges later
  task automatic edge_ev(input int ph, input logic ci, input int w, input logic pb,
                         input logic pa, input bit push, output int c);
    align(ph);
    clk_i = ci;
    clk_q = ~ci;
    din   = ~din;
    c     = cyc;
    if (push) q.push_back('{c + 3, w, pb, pa});
  endtask

  task automatic pulse_reset();
    @(posedge clk32);
    #1 rst = 1'b1;
    din = 1'b0;
    @(posedge clk32);
    #1 rst = 1'b0;
  endtask

  initial begin
    int c;
    rst = 1'b1; din = 1'b0; clk_i = 1'b0; clk_q = 1'b1;
    repeat (3) @(posedge clk32);
    #1 rst = 1'b0;

    // Idle: pulse trains only, no events
    gap(40);
    check("idle_walk", int'(walk), 0);

    // Four early edges -> +N_WALK -> pd_before
    edge_ev(0, 1'b1, 1, 1'b0, 1'b0, 1'b1, c); gap(8);
    edge_ev(0, 1'b1, 2, 1'b0, 1'b0, 1'b1, c); gap(8);
    edge_ev(0, 1'b1, 3, 1'b0, 1'b0, 1'b1, c); gap(8);
    edge_ev(0, 1'b1, 0, 1'b1, 1'b0, 1'b1, c);
    q.push_back('{c + 6, 0, 1'b0, 1'b0});
    gap(12);

    // Four late edges -> -N_WALK -> pd_after
    edge_ev(0, 1'b0, -1, 1'b0, 1'b0, 1'b1, c); gap(8);
    edge_ev(0, 1'b0, -2, 1'b0, 1'b0, 1'b1, c); gap(8);
    edge_ev(0, 1'b0, -3, 1'b0, 1'b0, 1'b1, c); gap(8);
    edge_ev(0, 1'b0, 0, 1'b0, 1'b1, 1'b1, c);
    q.push_back('{c + 4, 0, 1'b0, 1'b0});
    gap(12);

    // Alternating early/late: walk oscillates 1,0 with no correction
    for (int i = 0; i < 20; i++) begin
      edge_ev(2, (i % 2 == 0), (i % 2 == 0) ? 1 : 0, 1'b0, 1'b0, 1'b1, c);
      gap(8);
    end

    // Edges arriving while pd_before is pending are discarded
    edge_ev(0, 1'b1, 1, 1'b0, 1'b0, 1'b1, c); gap(8);
    edge_ev(0, 1'b1, 2, 1'b0, 1'b0, 1'b1, c); gap(8);
    edge_ev(0, 1'b1, 3, 1'b0, 1'b0, 1'b1, c); gap(8);
    edge_ev(3, 1'b1, 0, 1'b1, 1'b0, 1'b1, c);
    q.push_back('{c + 7, 0, 1'b0, 1'b0});
    repeat (3) begin
      @(negedge clk32);
      din = ~din;
    end
    gap(12);
    edge_ev(0, 1'b1, 1, 1'b0, 1'b0, 1'b1, c);
    gap(12);

    // Reset with walk at -2
    edge_ev(0, 1'b0, 0, 1'b0, 1'b0, 1'b1, c); gap(8);
    edge_ev(0, 1'b0, -1, 1'b0, 1'b0, 1'b1, c); gap(8);
    edge_ev(0, 1'b0, -2, 1'b0, 1'b0, 1'b1, c); gap(8);
    check("walk_before_reset", int'(walk), -2);
    pulse_reset();
    gap(12);
    check("walk_after_reset", int'(walk), 0);

    // Reset while pd_after is pending: the request must be dropped
    edge_ev(0, 1'b0, -1, 1'b0, 1'b0, 1'b1, c); gap(8);
    edge_ev(0, 1'b0, -2, 1'b0, 1'b0, 1'b1, c); gap(8);
    edge_ev(0, 1'b0, -3, 1'b0, 1'b0, 1'b1, c); gap(8);
    edge_ev(1, 1'b0, 0, 1'b0, 1'b1, 1'b1, c);
    repeat (3) @(posedge clk32);
    @(negedge clk32);
    check("pd_after_pending", int'(pd_after), 1);
    pulse_reset();
    gap(24);
    check("pd_after_dropped", int'(pd_after), 0);
    check("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
